// File: rtl/dvp_window3x3.sv
// Sliding 3x3 neighbourhood builder for the DVP pixel stream.
// Two line buffers hold the previous two rows; one window is emitted per interior pixel.
module dvp_window3x3 #(
    parameter int DATA_W     = 16,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  PCLK,
    input  logic                  Rst_p,
    input  logic                  DataValid,
    input  logic [DATA_W-1:0]     DataPixel,
    input  logic                  DataVs,
    output logic                  WinValid,
    output logic [9*DATA_W-1:0]   Window,
    output logic [11:0]           WinX,
    output logic [11:0]           WinY,
    output logic                  WinVs,
    output logic                  ErrPulse
);
    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [11:0] COL_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMG_HEIGHT - 1);

    logic [1:0]        state_reg;
    logic              vs_d_reg;
    logic [11:0]       col_reg, row_reg, col_next;
    logic              win_valid_reg, win_vs_reg, err_reg;
    logic [11:0]       win_x_reg, win_y_reg;
    logic              rise, accept, emit, is_last, err_next;

    logic [DATA_W-1:0] lb0_mem [0:IMG_WIDTH-1];
    logic [DATA_W-1:0] lb1_mem [0:IMG_WIDTH-1];
    logic [DATA_W-1:0] rd0_reg, rd1_reg;
    logic [AW-1:0]     rd_addr, wr_addr;

    logic [DATA_W-1:0] sh_reg  [0:8];
    logic [DATA_W-1:0] sh_next [0:8];
    logic [DATA_W-1:0] win_reg [0:8];
    logic [DATA_W-1:0] col_in  [0:2];

    assign rise     = DataVs & ~vs_d_reg;
    assign accept   = DataValid & ~rise & (state_reg == ST_ACTIVE);
    assign is_last  = (col_reg == COL_LAST) && (row_reg == ROW_LAST);
    assign emit     = accept && (col_reg >= 12'd2) && (row_reg >= 12'd2);
    assign err_next = (DataValid & (rise | (state_reg != ST_ACTIVE)))
                    | (rise & (state_reg == ST_ACTIVE) & ((col_reg | row_reg) != 12'd0));

    always_comb begin
        col_next = col_reg;
        if (rise)
            col_next = 12'd0;
        else if (accept)
            col_next = (col_reg == COL_LAST) ? 12'd0 : col_reg + 12'd1;
    end

    // Buffers are read one cycle ahead at the next column, so the registered read
    // data is already lb[col] when that pixel arrives; read and write never collide.
    assign rd_addr = col_next[AW-1:0];
    assign wr_addr = col_reg[AW-1:0];

    always_ff @(posedge PCLK) begin
        if (accept) begin
            lb0_mem[wr_addr] <= DataPixel;
            lb1_mem[wr_addr] <= rd0_reg;
        end
        rd0_reg <= lb0_mem[rd_addr];
        rd1_reg <= lb1_mem[rd_addr];
    end

    assign col_in[0] = rd1_reg;
    assign col_in[1] = rd0_reg;
    assign col_in[2] = DataPixel;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_shift
            assign sh_next[3*gi]     = sh_reg[3*gi+1];
            assign sh_next[3*gi + 1] = sh_reg[3*gi+2];
            assign sh_next[3*gi + 2] = col_in[gi];
        end
        for (gi = 0; gi < 9; gi++) begin : g_win
            assign Window[gi*DATA_W +: DATA_W] = win_reg[gi];
        end
    endgenerate

    // Shift register tracks every accepted pixel; the output copy only updates on emit.
    always_ff @(posedge PCLK or posedge Rst_p) begin
        if (Rst_p) begin
            for (int k = 0; k < 9; k++) begin
                sh_reg[k]  <= '0;
                win_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (accept) sh_reg[k]  <= sh_next[k];
                if (emit)   win_reg[k] <= sh_next[k];
            end
        end
    end

    always_ff @(posedge PCLK or posedge Rst_p) begin
        if (Rst_p) begin
            state_reg     <= ST_IDLE;
            vs_d_reg      <= 1'b0;
            col_reg       <= 12'd0;
            row_reg       <= 12'd0;
            win_valid_reg <= 1'b0;
            win_vs_reg    <= 1'b0;
            err_reg       <= 1'b0;
            win_x_reg     <= 12'd0;
            win_y_reg     <= 12'd0;
        end else begin
            vs_d_reg      <= DataVs;
            win_vs_reg    <= rise;
            err_reg       <= err_next;
            win_valid_reg <= emit;
            col_reg       <= col_next;
            if (emit) begin
                win_x_reg <= col_reg - 12'd1;
                win_y_reg <= row_reg - 12'd1;
            end
            if (rise) begin
                state_reg <= ST_ACTIVE;
                row_reg   <= 12'd0;
            end else if (accept && (col_reg == COL_LAST)) begin
                if (is_last) begin
                    state_reg <= ST_DONE;
                    row_reg   <= 12'd0;
                end else begin
                    row_reg   <= row_reg + 12'd1;
                end
            end
        end
    end

    assign WinValid = win_valid_reg;
    assign WinVs    = win_vs_reg;
    assign ErrPulse = err_reg;
    assign WinX     = win_x_reg;
    assign WinY     = win_y_reg;
endmodule

// File: tb/tb_dvp_window3x3.sv
// Directed bench for dvp_window3x3 on a 16x12 image; a negedge monitor checks every window.
`timescale 1ns/1ps
module tb_dvp_window3x3;
    localparam int W  = 16;
    localparam int H  = 12;
    localparam int DW = 16;

    logic            PCLK = 1'b0;
    logic            Rst_p;
    logic            DataValid;
    logic [DW-1:0]   DataPixel;
    logic            DataVs;
    logic            WinValid;
    logic [9*DW-1:0] Window;
    logic [11:0]     WinX, WinY;
    logic            WinVs, ErrPulse;

    int n_checks = 0;
    int n_fail   = 0;
    int pat      = 0;
    int win_cnt = 0, err_cnt = 0, vs_cnt = 0;
    int exp_x = 1, exp_y = 1;
    int first_pending = 0;
    int first_x, first_y, first_k0, first_k4, first_k8;
    int last_x, last_y, last_k4;

    dvp_window3x3 #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .PCLK(PCLK), .Rst_p(Rst_p), .DataValid(DataValid), .DataPixel(DataPixel),
        .DataVs(DataVs), .WinValid(WinValid), .Window(Window), .WinX(WinX),
        .WinY(WinY), .WinVs(WinVs), .ErrPulse(ErrPulse)
    );

    always #40 PCLK = ~PCLK;

    function automatic logic [DW-1:0] pix(input int p, input int x, input int y);
        int v;
        v = 16*y + x;
        return (p == 0) ? DW'(v) : DW'(255 - v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    always @(negedge PCLK) begin
        if (WinVs) begin
            vs_cnt++;
            exp_x = 1;
            exp_y = 1;
            first_pending = 1;
        end
        if (ErrPulse) err_cnt++;
        if (WinValid) begin
            win_cnt++;
            chk("win_x", WinX, exp_x);
            chk("win_y", WinY, exp_y);
            for (int k = 0; k < 9; k++)
                chk("win_px", Window[k*DW +: DW], pix(pat, exp_x - 1 + k % 3, exp_y - 1 + k / 3));
            if (first_pending != 0) begin
                first_pending = 0;
                first_x  = WinX;
                first_y  = WinY;
                first_k0 = Window[0 +: DW];
                first_k4 = Window[4*DW +: DW];
                first_k8 = Window[8*DW +: DW];
            end
            last_x  = WinX;
            last_y  = WinY;
            last_k4 = Window[4*DW +: DW];
            exp_x++;
            if (exp_x == W - 1) begin
                exp_x = 1;
                exp_y++;
            end
        end
    end

    task automatic vs_pulse(input int p);
        @(negedge PCLK);
        DataVs = 1'b1;
        pat    = p;
        repeat (2) @(negedge PCLK);
        DataVs = 1'b0;
        repeat (4) @(negedge PCLK);
    endtask

    task automatic send_line(input int p, input int y);
        for (int x = 0; x < W; x++) begin
            @(negedge PCLK);
            if (y == 2 && x == 2) chk("no_win_col1", WinValid, 0);
            if (y == 2 && x == 3) chk("first_latency", WinValid, 1);
            DataValid = 1'b1;
            DataPixel = pix(p, x, y);
        end
        @(negedge PCLK);
        DataValid = 1'b0;
        repeat (9) @(negedge PCLK);
    endtask

    task automatic send_frame(input int p);
        vs_pulse(p);
        for (int y = 0; y < H; y++) send_line(p, y);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, w0, v0, w1;
        Rst_p = 1'b1; DataValid = 1'b0; DataPixel = '0; DataVs = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_winvalid", WinValid, 0);
        chk("rst_err", ErrPulse, 0);
        chk("rst_winvs", WinVs, 0);
        chk("rst_winx", WinX, 0);
        chk("rst_window", Window == '0, 1);
        Rst_p = 1'b0;

        // 1: pixels with no frame start
        e0 = err_cnt; w0 = win_cnt;
        send_line(0, 0);
        chk("t1_err", err_cnt - e0, W);
        chk("t1_win", win_cnt - w0, 0);
        chk("t1_window", Window == '0, 1);
        chk("t1_winy", WinY, 0);

        // 2: one good frame
        e0 = err_cnt; w0 = win_cnt; v0 = vs_cnt;
        send_frame(0);
        chk("t2_vs", vs_cnt - v0, 1);
        chk("t2_win", win_cnt - w0, 140);
        chk("t2_err", err_cnt - e0, 0);
        chk("t2_first_x", first_x, 1);
        chk("t2_first_y", first_y, 1);
        chk("t2_first_k0", first_k0, 0);
        chk("t2_first_k4", first_k4, 17);
        chk("t2_first_k8", first_k8, 34);
        chk("t2_last_x", last_x, 14);
        chk("t2_last_y", last_y, 10);
        chk("t2_last_k4", last_k4, 174);

        // 3: back-to-back frames, second with inverted pattern
        w0 = win_cnt;
        send_frame(0);
        w1 = win_cnt;
        send_frame(1);
        chk("t3_win_f1", w1 - w0, 140);
        chk("t3_win_f2", win_cnt - w1, 140);
        chk("t3_first_k4", first_k4, 238);
        chk("t3_last_k4", last_k4, 255 - 174);

        // 4: short frame aborted by a new frame start
        vs_pulse(0);
        for (int y = 0; y < 5; y++) send_line(0, y);
        e0 = err_cnt; w0 = win_cnt;
        send_frame(0);
        chk("t4_err", err_cnt - e0, 1);
        chk("t4_win", win_cnt - w0, 140);
        chk("t4_last_k4", last_k4, 174);

        // 5: extra line after a complete frame
        e0 = err_cnt; w0 = win_cnt;
        send_line(0, 12);
        chk("t5_err", err_cnt - e0, W);
        chk("t5_win", win_cnt - w0, 0);

        // 6: asynchronous reset in the middle of line 6
        vs_pulse(0);
        for (int y = 0; y < 6; y++) send_line(0, y);
        for (int x = 0; x < 8; x++) begin
            @(negedge PCLK);
            DataValid = 1'b1;
            DataPixel = pix(0, x, 6);
        end
        @(negedge PCLK);
        DataValid = 1'b0;
        chk("t6_pre_window", Window != '0, 1);
        #15 Rst_p = 1'b1;
        #1;
        chk("t6_async_window", Window == '0, 1);
        chk("t6_async_winx", WinX, 0);
        chk("t6_async_winy", WinY, 0);
        repeat (2) @(negedge PCLK);
        Rst_p = 1'b0;
        e0 = err_cnt; w0 = win_cnt;
        for (int x = 0; x < 4; x++) begin
            @(negedge PCLK);
            DataValid = 1'b1;
            DataPixel = pix(0, x, 0);
        end
        @(negedge PCLK);
        DataValid = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("t6_err", err_cnt - e0, 4);
        chk("t6_win_none", win_cnt - w0, 0);
        w0 = win_cnt; v0 = vs_cnt;
        send_frame(0);
        chk("t6_win", win_cnt - w0, 140);
        chk("t6_vs", vs_cnt - v0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
